// File: rtl/sap1_control_unit.sv
// SAP-1 controller/sequencer.
// Decodes the one-hot T-state from the ring counter and the IR opcode into the
// 12-bit control word {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo}.
// It also sequences run/halt/fault, counts retired instructions and checks
// that the ring counter is one-hot.
// Optional build macro: SAP1_ILLOP_TRAP_EN. When it is defined, an
// unrecognised opcode at T4 traps to FAULT instead of executing as a NOP.
module sap1_control_unit #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       t,
    input  logic [3:0]       opcode,
    output logic [11:0]      con,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned T_W   = 6;
    localparam int unsigned CON_W = 12;

    // T-state encodings
    localparam logic [T_W-1:0] T1 = 6'b100000;
    localparam logic [T_W-1:0] T2 = 6'b010000;
    localparam logic [T_W-1:0] T3 = 6'b001000;
    localparam logic [T_W-1:0] T4 = 6'b000100;
    localparam logic [T_W-1:0] T5 = 6'b000010;
    localparam logic [T_W-1:0] T6 = 6'b000001;

    // Opcodes
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Control word bit positions
    localparam int unsigned B_CP = 11;
    localparam int unsigned B_EP = 10;
    localparam int unsigned B_LM = 9;
    localparam int unsigned B_CE = 8;
    localparam int unsigned B_LI = 7;
    localparam int unsigned B_EI = 6;
    localparam int unsigned B_LA = 5;
    localparam int unsigned B_EA = 4;
    localparam int unsigned B_SU = 3;
    localparam int unsigned B_EU = 2;
    localparam int unsigned B_LB = 1;
    localparam int unsigned B_LO = 0;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              t_ok;
    logic [CON_W-1:0]  con_dec;

    // Ring counter sanity: exactly one bit set
    assign t_ok = (t != '0) && ((t & (t - T_W'(1))) == '0);

`ifdef SAP1_ILLOP_TRAP_EN
    logic op_illegal;

    // Opcodes outside the implemented set
    always_comb begin
        op_illegal = 1'b1;
        case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT: op_illegal = 1'b0;
            default:                                op_illegal = 1'b1;
        endcase
    end
`endif

    // State register, plus status flags registered from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_WAIT;
            halted <= 1'b0;
            fault  <= 1'b0;
        end else begin
            state  <= state_nxt;
            halted <= (state_nxt == S_HALT);
            fault  <= (state_nxt == S_FAULT);
        end
    end

    // Control word decode, gating and next-state logic
    always_comb begin
        state_nxt = state;
        con_dec   = '0;
        con       = '0;

        case (t)
            T1: begin
                con_dec[B_EP] = 1'b1;
                con_dec[B_LM] = 1'b1;
            end
            T2: con_dec[B_CP] = 1'b1;
            T3: begin
                con_dec[B_CE] = 1'b1;
                con_dec[B_LI] = 1'b1;
            end
            T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        con_dec[B_EI] = 1'b1;
                        con_dec[B_LM] = 1'b1;
                    end
                    OP_OUT: begin
                        con_dec[B_EA] = 1'b1;
                        con_dec[B_LO] = 1'b1;
                    end
                    default: con_dec = '0;
                endcase
            end
            T5: begin
                case (opcode)
                    OP_LDA: begin
                        con_dec[B_CE] = 1'b1;
                        con_dec[B_LA] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        con_dec[B_CE] = 1'b1;
                        con_dec[B_LB] = 1'b1;
                    end
                    default: con_dec = '0;
                endcase
            end
            T6: begin
                case (opcode)
                    OP_ADD: begin
                        con_dec[B_EU] = 1'b1;
                        con_dec[B_LA] = 1'b1;
                    end
                    OP_SUB: begin
                        con_dec[B_SU] = 1'b1;
                        con_dec[B_EU] = 1'b1;
                        con_dec[B_LA] = 1'b1;
                    end
                    default: con_dec = '0;
                endcase
            end
            default: con_dec = '0;
        endcase

        // The first T1 is already issued while waiting for the ring counter
        if ((state == S_RUN) || ((state == S_WAIT) && (t == T1))) begin
            con = con_dec;
        end

        case (state)
            S_WAIT: begin
                if (!t_ok) begin
                    state_nxt = S_FAULT;
                end else if (t == T1) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!t_ok) begin
                    state_nxt = S_FAULT;
                end else if ((t == T4) && (opcode == OP_HLT)) begin
                    state_nxt = S_HALT;
`ifdef SAP1_ILLOP_TRAP_EN
                end else if ((t == T4) && op_illegal) begin
                    state_nxt = S_FAULT;
`endif
                end
            end
            S_HALT:  state_nxt = S_HALT;
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_FAULT;
        endcase
    end

    // Retired-instruction counter: one count per T6 spent in RUN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if ((state == S_RUN) && (t == T6)) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule
